// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// flush, downstream stall and a saturating bubble counter.
module id_ex_pipe_reg #(
  parameter int XLEN      = 32,
  parameter int IMM_W     = 64,
  parameter int REG_AW    = 5,
  parameter int ALUOP_W   = 5,
  parameter int CNT_W     = 16,
  parameter int HAZARD_EN = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               IF_ID_Valid,
  input  logic [XLEN-1:0]    IF_ID_PC,
  input  logic [XLEN-1:0]    IF_ID_read1_data,
  input  logic [XLEN-1:0]    IF_ID_read2_data,
  input  logic [IMM_W-1:0]   IF_ID_imm,
  input  logic [REG_AW-1:0]  IF_ID_RS1,
  input  logic [REG_AW-1:0]  IF_ID_RS2,
  input  logic [REG_AW-1:0]  IF_ID_RD,
  input  logic               IF_ID_UsesRS1,
  input  logic               IF_ID_UsesRS2,
  input  logic               CTRL_RegWrite,
  input  logic               CTRL_MemtoReg,
  input  logic               CTRL_MEM_MemWrite,
  input  logic               CTRL_MEM_MemRead,
  input  logic               CTRL_MEM_Branch,
  input  logic               CTRL_ALUSrc,
  input  logic [ALUOP_W-1:0] CTRL_ALUOp,
  input  logic               EX_Stall,
  input  logic               Flush,
  output logic               ID_EX_Valid,
  output logic [XLEN-1:0]    ID_EX_PC,
  output logic [XLEN-1:0]    ID_EX_read1_data,
  output logic [XLEN-1:0]    ID_EX_read2_data,
  output logic [IMM_W-1:0]   ID_EX_imm,
  output logic [REG_AW-1:0]  ID_EX_RS1,
  output logic [REG_AW-1:0]  ID_EX_RS2,
  output logic [REG_AW-1:0]  ID_EX_RD,
  output logic               ID_EX_RegWrite,
  output logic               ID_EX_MemtoReg,
  output logic               ID_EX_MemWrite,
  output logic               ID_EX_MemRead,
  output logic               ID_EX_Branch,
  output logic               ID_EX_ALUSrc,
  output logic [ALUOP_W-1:0] ID_EX_ALUOp,
  output logic               Hazard_Stall,
  output logic [CNT_W-1:0]   Bubble_Count
);

  logic               valid_q, valid_d;
  logic [XLEN-1:0]    pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d;
  logic [IMM_W-1:0]   imm_q, imm_d;
  logic [REG_AW-1:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic               reg_write_q, reg_write_d, mem_to_reg_q, mem_to_reg_d;
  logic               mem_write_q, mem_write_d, mem_read_q, mem_read_d;
  logic               branch_q, branch_d, alu_src_q, alu_src_d;
  logic [ALUOP_W-1:0] alu_op_q, alu_op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic rs1_match, rs2_match, load_use;

  // A load sitting in EX whose destination is a source the ID instruction really reads
  assign rs1_match = IF_ID_UsesRS1 && (IF_ID_RS1 == rd_q);
  assign rs2_match = IF_ID_UsesRS2 && (IF_ID_RS2 == rd_q);
  assign load_use  = (HAZARD_EN != 0) && valid_q && mem_read_q && (rd_q != '0) &&
                     IF_ID_Valid && (rs1_match || rs2_match);
  // A flushed ID instruction never needs the load result, so no stall
  assign Hazard_Stall = load_use && !Flush;

  // Next-slot selection: flush, then EX hold, then hazard bubble, then load
  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    rd1_d        = rd1_q;
    rd2_d        = rd2_q;
    imm_d        = imm_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    mem_write_d  = mem_write_q;
    mem_read_d   = mem_read_q;
    branch_d     = branch_q;
    alu_src_d    = alu_src_q;
    alu_op_d     = alu_op_q;
    cnt_d        = cnt_q;
    if (Flush || (!EX_Stall && Hazard_Stall)) begin
      // Bubble: kill valid and control, leave data fields as they were
      valid_d      = 1'b0;
      reg_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      mem_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      branch_d     = 1'b0;
      alu_src_d    = 1'b0;
      alu_op_d     = '0;
      if (!Flush && cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (!EX_Stall) begin
      valid_d      = IF_ID_Valid;
      pc_d         = IF_ID_PC;
      rd1_d        = IF_ID_read1_data;
      rd2_d        = IF_ID_read2_data;
      imm_d        = IF_ID_imm;
      rs1_d        = IF_ID_RS1;
      rs2_d        = IF_ID_RS2;
      rd_d         = IF_ID_RD;
      reg_write_d  = IF_ID_Valid && CTRL_RegWrite;
      mem_to_reg_d = IF_ID_Valid && CTRL_MemtoReg;
      mem_write_d  = IF_ID_Valid && CTRL_MEM_MemWrite;
      mem_read_d   = IF_ID_Valid && CTRL_MEM_MemRead;
      branch_d     = IF_ID_Valid && CTRL_MEM_Branch;
      alu_src_d    = IF_ID_Valid && CTRL_ALUSrc;
      alu_op_d     = IF_ID_Valid ? CTRL_ALUOp : '0;
    end
  end

  // Slot register with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      branch_q     <= 1'b0;
      alu_src_q    <= 1'b0;
      alu_op_q     <= '0;
      cnt_q        <= '0;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      rd1_q        <= rd1_d;
      rd2_q        <= rd2_d;
      imm_q        <= imm_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      mem_write_q  <= mem_write_d;
      mem_read_q   <= mem_read_d;
      branch_q     <= branch_d;
      alu_src_q    <= alu_src_d;
      alu_op_q     <= alu_op_d;
      cnt_q        <= cnt_d;
    end
  end

  assign ID_EX_Valid      = valid_q;
  assign ID_EX_PC         = pc_q;
  assign ID_EX_read1_data = rd1_q;
  assign ID_EX_read2_data = rd2_q;
  assign ID_EX_imm        = imm_q;
  assign ID_EX_RS1        = rs1_q;
  assign ID_EX_RS2        = rs2_q;
  assign ID_EX_RD         = rd_q;
  assign ID_EX_RegWrite   = reg_write_q;
  assign ID_EX_MemtoReg   = mem_to_reg_q;
  assign ID_EX_MemWrite   = mem_write_q;
  assign ID_EX_MemRead    = mem_read_q;
  assign ID_EX_Branch     = branch_q;
  assign ID_EX_ALUSrc     = alu_src_q;
  assign ID_EX_ALUOp      = alu_op_q;
  assign Bubble_Count     = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: a driver pushes model predictions,
// a monitor pops and compares them against two DUT instances (16-bit and
// 2-bit bubble counters).
module tb_id_ex_pipe_reg;

  typedef struct {
    logic        rst, valid, flush, exs, u1, u2;
    logic [31:0] pc, r1, r2;
    logic [63:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, m2r, mw, mr, br, as;
    logic [4:0]  aluop;
  } stim_t;

  typedef struct {
    logic        haz_chk, haz;
    logic        valid;
    logic [31:0] pc, r1, r2;
    logic [63:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, m2r, mw, mr, br, as;
    logic [4:0]  aluop;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, IF_ID_Valid, IF_ID_UsesRS1, IF_ID_UsesRS2;
  logic [31:0] IF_ID_PC, IF_ID_read1_data, IF_ID_read2_data;
  logic [63:0] IF_ID_imm;
  logic [4:0]  IF_ID_RS1, IF_ID_RS2, IF_ID_RD, CTRL_ALUOp;
  logic        CTRL_RegWrite, CTRL_MemtoReg, CTRL_MEM_MemWrite, CTRL_MEM_MemRead;
  logic        CTRL_MEM_Branch, CTRL_ALUSrc, EX_Stall, Flush;

  logic        ID_EX_Valid, ID_EX_RegWrite, ID_EX_MemtoReg, ID_EX_MemWrite;
  logic        ID_EX_MemRead, ID_EX_Branch, ID_EX_ALUSrc, Hazard_Stall;
  logic [31:0] ID_EX_PC, ID_EX_read1_data, ID_EX_read2_data;
  logic [63:0] ID_EX_imm;
  logic [4:0]  ID_EX_RS1, ID_EX_RS2, ID_EX_RD, ID_EX_ALUOp;
  logic [15:0] Bubble_Count;

  logic        s_valid, s_rw, s_m2r, s_mw, s_mr, s_br, s_as, s_haz;
  logic [31:0] s_pc, s_r1, s_r2;
  logic [63:0] s_imm;
  logic [4:0]  s_rs1, s_rs2, s_rd, s_aluop;
  logic [1:0]  s_cnt;

  id_ex_pipe_reg dut (
    .clk(clk), .rst(rst), .IF_ID_Valid(IF_ID_Valid), .IF_ID_PC(IF_ID_PC),
    .IF_ID_read1_data(IF_ID_read1_data), .IF_ID_read2_data(IF_ID_read2_data),
    .IF_ID_imm(IF_ID_imm), .IF_ID_RS1(IF_ID_RS1), .IF_ID_RS2(IF_ID_RS2), .IF_ID_RD(IF_ID_RD),
    .IF_ID_UsesRS1(IF_ID_UsesRS1), .IF_ID_UsesRS2(IF_ID_UsesRS2),
    .CTRL_RegWrite(CTRL_RegWrite), .CTRL_MemtoReg(CTRL_MemtoReg),
    .CTRL_MEM_MemWrite(CTRL_MEM_MemWrite), .CTRL_MEM_MemRead(CTRL_MEM_MemRead),
    .CTRL_MEM_Branch(CTRL_MEM_Branch), .CTRL_ALUSrc(CTRL_ALUSrc), .CTRL_ALUOp(CTRL_ALUOp),
    .EX_Stall(EX_Stall), .Flush(Flush),
    .ID_EX_Valid(ID_EX_Valid), .ID_EX_PC(ID_EX_PC), .ID_EX_read1_data(ID_EX_read1_data),
    .ID_EX_read2_data(ID_EX_read2_data), .ID_EX_imm(ID_EX_imm), .ID_EX_RS1(ID_EX_RS1),
    .ID_EX_RS2(ID_EX_RS2), .ID_EX_RD(ID_EX_RD), .ID_EX_RegWrite(ID_EX_RegWrite),
    .ID_EX_MemtoReg(ID_EX_MemtoReg), .ID_EX_MemWrite(ID_EX_MemWrite),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Branch(ID_EX_Branch), .ID_EX_ALUSrc(ID_EX_ALUSrc),
    .ID_EX_ALUOp(ID_EX_ALUOp), .Hazard_Stall(Hazard_Stall), .Bubble_Count(Bubble_Count)
  );

  id_ex_pipe_reg #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .IF_ID_Valid(IF_ID_Valid), .IF_ID_PC(IF_ID_PC),
    .IF_ID_read1_data(IF_ID_read1_data), .IF_ID_read2_data(IF_ID_read2_data),
    .IF_ID_imm(IF_ID_imm), .IF_ID_RS1(IF_ID_RS1), .IF_ID_RS2(IF_ID_RS2), .IF_ID_RD(IF_ID_RD),
    .IF_ID_UsesRS1(IF_ID_UsesRS1), .IF_ID_UsesRS2(IF_ID_UsesRS2),
    .CTRL_RegWrite(CTRL_RegWrite), .CTRL_MemtoReg(CTRL_MemtoReg),
    .CTRL_MEM_MemWrite(CTRL_MEM_MemWrite), .CTRL_MEM_MemRead(CTRL_MEM_MemRead),
    .CTRL_MEM_Branch(CTRL_MEM_Branch), .CTRL_ALUSrc(CTRL_ALUSrc), .CTRL_ALUOp(CTRL_ALUOp),
    .EX_Stall(EX_Stall), .Flush(Flush),
    .ID_EX_Valid(s_valid), .ID_EX_PC(s_pc), .ID_EX_read1_data(s_r1),
    .ID_EX_read2_data(s_r2), .ID_EX_imm(s_imm), .ID_EX_RS1(s_rs1),
    .ID_EX_RS2(s_rs2), .ID_EX_RD(s_rd), .ID_EX_RegWrite(s_rw),
    .ID_EX_MemtoReg(s_m2r), .ID_EX_MemWrite(s_mw),
    .ID_EX_MemRead(s_mr), .ID_EX_Branch(s_br), .ID_EX_ALUSrc(s_as),
    .ID_EX_ALUOp(s_aluop), .Hazard_Stall(s_haz), .Bubble_Count(s_cnt)
  );

  exp_t exp_q[$];
  exp_t m;
  logic m_known = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: what the EX slot should hold, from the stated rules
  task automatic apply(input stim_t s);
    exp_t n;
    logic haz;
    @(negedge clk);
    rst = s.rst; IF_ID_Valid = s.valid; Flush = s.flush; EX_Stall = s.exs;
    IF_ID_PC = s.pc; IF_ID_read1_data = s.r1; IF_ID_read2_data = s.r2; IF_ID_imm = s.imm;
    IF_ID_RS1 = s.rs1; IF_ID_RS2 = s.rs2; IF_ID_RD = s.rd;
    IF_ID_UsesRS1 = s.u1; IF_ID_UsesRS2 = s.u2;
    CTRL_RegWrite = s.rw; CTRL_MemtoReg = s.m2r; CTRL_MEM_MemWrite = s.mw;
    CTRL_MEM_MemRead = s.mr; CTRL_MEM_Branch = s.br; CTRL_ALUSrc = s.as; CTRL_ALUOp = s.aluop;

    haz = m.valid && m.mr && (m.rd != 0) && s.valid &&
          ((s.u1 && s.rs1 == m.rd) || (s.u2 && s.rs2 == m.rd)) && !s.flush;
    n = m;
    if (s.rst) begin
      n = '{default: '0};
    end else if (s.flush || (!s.exs && haz)) begin
      n.valid = 0; n.rw = 0; n.m2r = 0; n.mw = 0; n.mr = 0; n.br = 0; n.as = 0; n.aluop = 0;
      if (!s.flush) begin
        n.cnt  = (m.cnt == 16'hFFFF) ? m.cnt : m.cnt + 16'd1;
        n.cnt2 = (m.cnt2 == 2'd3) ? m.cnt2 : m.cnt2 + 2'd1;
      end
    end else if (!s.exs) begin
      n.valid = s.valid; n.pc = s.pc; n.r1 = s.r1; n.r2 = s.r2; n.imm = s.imm;
      n.rs1 = s.rs1; n.rs2 = s.rs2; n.rd = s.rd;
      n.rw = s.valid & s.rw; n.m2r = s.valid & s.m2r; n.mw = s.valid & s.mw;
      n.mr = s.valid & s.mr; n.br = s.valid & s.br; n.as = s.valid & s.as;
      n.aluop = s.valid ? s.aluop : 5'd0;
    end
    n.haz_chk = m_known;
    n.haz = haz;
    exp_q.push_back(n);
    m = n;
    if (s.rst) m_known = 1'b1;
  endtask

  function automatic stim_t rnd();
    stim_t s;
    s.rst = ($urandom_range(0, 99) == 0); s.valid = ($urandom_range(0, 99) < 85);
    s.flush = ($urandom_range(0, 99) < 8); s.exs = ($urandom_range(0, 99) < 15);
    s.pc = $urandom; s.r1 = $urandom; s.r2 = $urandom; s.imm = {$urandom, $urandom};
    s.rs1 = 5'($urandom_range(0, 7)); s.rs2 = 5'($urandom_range(0, 7));
    s.rd = 5'($urandom_range(0, 7));
    s.u1 = 1'($urandom); s.u2 = 1'($urandom);
    s.rw = 1'($urandom); s.m2r = 1'($urandom); s.mw = 1'($urandom);
    s.mr = ($urandom_range(0, 99) < 40); s.br = 1'($urandom); s.as = 1'($urandom);
    s.aluop = 5'($urandom);
    return s;
  endfunction

  function automatic stim_t quiet();
    stim_t s = rnd();
    s.rst = 0; s.valid = 1; s.flush = 0; s.exs = 0; s.u1 = 0; s.u2 = 0; s.mr = 0;
    return s;
  endfunction

  function automatic stim_t lw(input logic [4:0] rd);
    stim_t s = quiet();
    s.mr = 1; s.rw = 1; s.rd = rd;
    return s;
  endfunction

  function automatic stim_t dep_rs2(input logic [4:0] r, input logic use2);
    stim_t s = quiet();
    s.rs2 = r; s.u2 = use2; s.rs1 = 5'd9; s.u1 = 1; s.rd = 5'd10;
    return s;
  endfunction

  // Monitor: hazard sampled late in the cycle, slot contents just after the edge
  initial begin
    exp_t e;
    logic haz_s;
    forever begin
      @(negedge clk);
      #4 haz_s = Hazard_Stall;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.haz_chk) chk("hazard_stall", haz_s, e.haz);
        chk("valid", ID_EX_Valid, e.valid);
        chk("pc", ID_EX_PC, e.pc);
        chk("read1", ID_EX_read1_data, e.r1);
        chk("read2", ID_EX_read2_data, e.r2);
        chk("imm", ID_EX_imm, e.imm);
        chk("regs", {ID_EX_RS1, ID_EX_RS2, ID_EX_RD}, {e.rs1, e.rs2, e.rd});
        chk("ctrl", {ID_EX_RegWrite, ID_EX_MemtoReg, ID_EX_MemWrite, ID_EX_MemRead,
                     ID_EX_Branch, ID_EX_ALUSrc, ID_EX_ALUOp},
                    {e.rw, e.m2r, e.mw, e.mr, e.br, e.as, e.aluop});
        chk("bubble_count", Bubble_Count, e.cnt);
        chk("bubble_count_sat", s_cnt, e.cnt2);
        chk("sat_valid", s_valid, e.valid);
      end
    end
  end

  initial begin
    stim_t s;
    int wait_cyc;
    rst = 1; IF_ID_Valid = 0; Flush = 0; EX_Stall = 0;
    IF_ID_PC = 0; IF_ID_read1_data = 0; IF_ID_read2_data = 0; IF_ID_imm = 0;
    IF_ID_RS1 = 0; IF_ID_RS2 = 0; IF_ID_RD = 0; IF_ID_UsesRS1 = 0; IF_ID_UsesRS2 = 0;
    CTRL_RegWrite = 0; CTRL_MemtoReg = 0; CTRL_MEM_MemWrite = 0; CTRL_MEM_MemRead = 0;
    CTRL_MEM_Branch = 0; CTRL_ALUSrc = 0; CTRL_ALUOp = 0;
    m = '{default: '0};

    for (int i = 0; i < 2; i++) begin
      s = rnd(); s.rst = 1; apply(s);
    end

    // plain flow
    s = quiet(); s.pc = 32'h100; s.imm = 64'h5; s.rd = 5'd3; s.aluop = 5'h2; apply(s);
    @(posedge clk); #2;
    chk("plain_pc", ID_EX_PC, 64'h100);
    chk("plain_rd", ID_EX_RD, 64'd3);
    chk("plain_aluop", ID_EX_ALUOp, 64'd2);
    chk("plain_valid", ID_EX_Valid, 64'd1);

    // load-use, one bubble, then dependent loads
    apply(lw(5'd5));
    s = dep_rs2(5'd5, 1'b1); apply(s);
    @(posedge clk); #2;
    chk("lu_bubble_valid", ID_EX_Valid, 64'd0);
    chk("lu_bubble_count", Bubble_Count, 64'd1);
    apply(s);
    apply(lw(5'd5)); apply(dep_rs2(5'd5, 1'b0));
    apply(lw(5'd0)); apply(dep_rs2(5'd0, 1'b1));

    // EX_Stall holds through a pending hazard, then one bubble
    apply(lw(5'd7));
    for (int i = 0; i < 3; i++) begin
      s = dep_rs2(5'd7, 1'b1); s.exs = 1; apply(s);
    end
    s.exs = 0; apply(s); apply(s);

    // flush beats stall and hazard
    apply(lw(5'd6));
    s = quiet(); s.rs1 = 5'd6; s.u1 = 1; s.flush = 1; s.exs = 1; apply(s);

    // repeated load-use bubbles drive the 2-bit counter into saturation
    for (int i = 0; i < 5; i++) begin
      apply(lw(5'd4));
      s = dep_rs2(5'd4, 1'b1); apply(s); apply(s);
    end

    for (int i = 0; i < 3000; i++) apply(rnd());

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
